// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the fetch/data memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    MSIZE_BYTE = 2'd0,
    MSIZE_HALF = 2'd1,
    MSIZE_WORD = 2'd2
  } msize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IBUS = 2'd1,
    DBUS = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              write;
    msize_t            size;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

  // Instruction fetches are always word-sized reads with no store data.
  function automatic bus_cmd_t fetch_cmd(input logic [ADDR_W-1:0] addr);
    bus_cmd_t c;
    c.write = 1'b0;
    c.size  = MSIZE_WORD;
    c.addr  = addr;
    c.wdata = '0;
    return c;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester ports, stall lines and shared memory bus of the arbiter.
// master = the arbiter (drives the bus and the responses),
// slave  = its environment (requesters and the bus slave).
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic              ireq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic              iresp_valid;
  logic [DATA_W-1:0] iresp_data;

  logic              dreq_valid;
  logic              dreq_write;
  logic [ADDR_W-1:0] dreq_addr;
  msize_t            dreq_size;
  logic [DATA_W-1:0] dreq_wdata;
  logic              dresp_valid;
  logic [DATA_W-1:0] dresp_data;

  logic              stall_i;
  logic              stall_d;

  logic              bus_req;
  logic              bus_write;
  logic [ADDR_W-1:0] bus_addr;
  msize_t            bus_size;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    input  ireq_valid, ireq_addr,
    input  dreq_valid, dreq_write, dreq_addr, dreq_size, dreq_wdata,
    input  bus_ack, bus_rdata,
    output iresp_valid, iresp_data, dresp_valid, dresp_data,
    output stall_i, stall_d,
    output bus_req, bus_write, bus_addr, bus_size, bus_wdata
  );

  modport slave (
    output ireq_valid, ireq_addr,
    output dreq_valid, dreq_write, dreq_addr, dreq_size, dreq_wdata,
    output bus_ack, bus_rdata,
    input  iresp_valid, iresp_data, dresp_valid, dresp_data,
    input  stall_i, stall_d,
    input  bus_req, bus_write, bus_addr, bus_size, bus_wdata
  );

endinterface

// File: rtl/mem_bus_arbiter_streak_ctr.sv
// Counts data grants won against a waiting fetch; at the limit fetch is forced.
module mem_bus_arbiter_streak_ctr
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic d_grant,
  input  logic i_grant,
  input  logic i_pending,
  output logic force_i
);

  localparam logic [STREAK_W-1:0] MAX_L = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak_p0;

  // Saturating streak: grows only while fetch is losing, clears otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      streak_p0 <= '0;
    end else if (i_grant) begin
      streak_p0 <= '0;
    end else if (d_grant) begin
      if (!i_pending) begin
        streak_p0 <= '0;
      end else if (streak_p0 != MAX_L) begin
        streak_p0 <= streak_p0 + 1'b1;
      end
    end
  end

  assign force_i = (streak_p0 == MAX_L);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and the memory stage,
// one transaction at a time, data first with a fetch starvation guard.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic                clk,
  input  logic                resetn,
  mem_bus_arbiter_if.master   mb
);

  arb_state_t        state_p0;
  bus_cmd_t          cmd_p0;
  logic              breq_p0;
  logic              iresp_vld_p1;
  logic              dresp_vld_p1;
  logic [DATA_W-1:0] iresp_data_p1;
  logic [DATA_W-1:0] dresp_data_p1;

  logic i_eff;
  logic d_eff;
  logic idle;
  logic force_i;
  logic grant_d;
  logic grant_i;

  // A requester still showing valid in its own response cycle is the old
  // request, so it is masked until the following cycle.
  assign i_eff   = mb.ireq_valid && !iresp_vld_p1;
  assign d_eff   = mb.dreq_valid && !dresp_vld_p1;
  assign idle    = (state_p0 == IDLE);
  assign grant_d = idle && d_eff && !(i_eff && force_i);
  assign grant_i = idle && i_eff && !grant_d;

  mem_bus_arbiter_streak_ctr #(
    .MAX_D_STREAK (MAX_D_STREAK)
  ) u_streak (
    .clk       (clk),
    .resetn    (resetn),
    .d_grant   (grant_d),
    .i_grant   (grant_i),
    .i_pending (i_eff),
    .force_i   (force_i)
  );

  // Arbitration FSM: latch the granted command, hold it until ack, then
  // register the read data and pulse the matching response for one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_p0      <= IDLE;
      cmd_p0        <= '0;
      breq_p0       <= 1'b0;
      iresp_vld_p1  <= 1'b0;
      dresp_vld_p1  <= 1'b0;
      iresp_data_p1 <= '0;
      dresp_data_p1 <= '0;
    end else begin
      iresp_vld_p1 <= 1'b0;
      dresp_vld_p1 <= 1'b0;
      unique case (state_p0)
        IDLE: begin
          if (grant_d) begin
            cmd_p0.write <= mb.dreq_write;
            cmd_p0.size  <= mb.dreq_size;
            cmd_p0.addr  <= mb.dreq_addr;
            cmd_p0.wdata <= mb.dreq_wdata;
            breq_p0      <= 1'b1;
            state_p0     <= DBUS;
          end else if (grant_i) begin
            cmd_p0   <= fetch_cmd(mb.ireq_addr);
            breq_p0  <= 1'b1;
            state_p0 <= IBUS;
          end
        end
        IBUS: begin
          if (mb.bus_ack) begin
            iresp_data_p1 <= mb.bus_rdata;
            iresp_vld_p1  <= 1'b1;
            breq_p0       <= 1'b0;
            state_p0      <= IDLE;
          end
        end
        DBUS: begin
          if (mb.bus_ack) begin
            dresp_data_p1 <= mb.bus_rdata;
            dresp_vld_p1  <= 1'b1;
            breq_p0       <= 1'b0;
            state_p0      <= IDLE;
          end
        end
        default: begin
          breq_p0  <= 1'b0;
          state_p0 <= IDLE;
        end
      endcase
    end
  end

  assign mb.bus_req     = breq_p0;
  assign mb.bus_write   = cmd_p0.write;
  assign mb.bus_size    = cmd_p0.size;
  assign mb.bus_addr    = cmd_p0.addr;
  assign mb.bus_wdata   = cmd_p0.wdata;
  assign mb.iresp_valid = iresp_vld_p1;
  assign mb.iresp_data  = iresp_data_p1;
  assign mb.dresp_valid = dresp_vld_p1;
  assign mb.dresp_data  = dresp_data_p1;
  assign mb.stall_i     = i_eff;
  assign mb.stall_d     = d_eff;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a transaction-level reference model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int MAX_D = 4;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_bus_arbiter_if mb();

  mem_bus_arbiter #(.MAX_D_STREAK(MAX_D)) dut (
    .clk    (clk),
    .resetn (resetn),
    .mb     (mb)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- bus slave ----------------
  logic        slave_en    = 1'b1;
  logic        auto_ack    = 1'b0;
  logic        man_ack     = 1'b0;
  logic        rd_fixed_en = 1'b0;
  logic [31:0] rd_fixed    = 32'h0;
  int          ack_lat     = 1;
  int          slave_cnt   = 0;

  assign mb.bus_ack   = slave_en ? auto_ack : man_ack;
  assign mb.bus_rdata = rd_fixed_en ? rd_fixed : (mb.bus_addr ^ 32'hC0DE_0000);

  always @(posedge clk) begin
    #1;
    if (mb.bus_req && (slave_cnt + 1 >= ack_lat)) begin
      auto_ack  = 1'b1;
      slave_cnt = 0;
    end else if (mb.bus_req) begin
      auto_ack  = 1'b0;
      slave_cnt = slave_cnt + 1;
    end else begin
      auto_ack  = 1'b0;
      slave_cnt = 0;
    end
  end

  // ---------------- reference model ----------------
  // m_busy: 0 = bus free, 1 = fetch owns bus, 2 = data owns bus.
  int          m_busy   = 0;
  logic        m_w      = 1'b0;
  logic [1:0]  m_sz     = 2'd0;
  logic [31:0] m_a      = 32'h0;
  logic [31:0] m_wd     = 32'h0;
  logic        m_ivld   = 1'b0;
  logic        m_dvld   = 1'b0;
  logic [31:0] m_idata  = 32'h0;
  logic [31:0] m_ddata  = 32'h0;
  logic        m_dknown = 1'b1;
  int          m_streak = 0;
  int          m_grants[$];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_busy = 0; m_w = 1'b0; m_sz = 2'd0; m_a = 32'h0; m_wd = 32'h0;
      m_ivld = 1'b0; m_dvld = 1'b0; m_idata = 32'h0; m_ddata = 32'h0;
      m_dknown = 1'b1; m_streak = 0;
    end else begin
      bit ie, de;
      ie = mb.ireq_valid && !m_ivld;
      de = mb.dreq_valid && !m_dvld;
      m_ivld = 1'b0;
      m_dvld = 1'b0;
      if (m_busy == 0) begin
        if (de && !(ie && m_streak == MAX_D)) begin
          m_busy = 2;
          m_w = mb.dreq_write; m_sz = mb.dreq_size; m_a = mb.dreq_addr; m_wd = mb.dreq_wdata;
          m_streak = ie ? ((m_streak < MAX_D) ? m_streak + 1 : MAX_D) : 0;
          m_grants.push_back(2);
        end else if (ie) begin
          m_busy = 1;
          m_w = 1'b0; m_sz = 2'd2; m_a = mb.ireq_addr; m_wd = 32'h0;
          m_streak = 0;
          m_grants.push_back(1);
        end
      end else if (mb.bus_ack) begin
        if (m_busy == 1) begin
          m_ivld  = 1'b1;
          m_idata = mb.bus_rdata;
        end else begin
          m_dvld = 1'b1;
          if (!m_w) begin
            m_ddata  = mb.bus_rdata;
            m_dknown = 1'b1;
          end else begin
            m_dknown = 1'b0;
          end
        end
        m_busy = 0;
      end
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    chk("bus_req",     32'(mb.bus_req),     32'(m_busy != 0));
    chk("bus_write",   32'(mb.bus_write),   32'(m_w));
    chk("bus_size",    32'(mb.bus_size),    32'(m_sz));
    chk("bus_addr",    mb.bus_addr,         m_a);
    chk("bus_wdata",   mb.bus_wdata,        m_wd);
    chk("iresp_valid", 32'(mb.iresp_valid), 32'(m_ivld));
    chk("dresp_valid", 32'(mb.dresp_valid), 32'(m_dvld));
    chk("iresp_data",  mb.iresp_data,       m_idata);
    if (m_dknown) chk("dresp_data", mb.dresp_data, m_ddata);
    chk("stall_i", 32'(mb.stall_i), 32'(mb.ireq_valid && !m_ivld));
    chk("stall_d", 32'(mb.stall_d), 32'(mb.dreq_valid && !m_dvld));
  end

  // ---------------- per-cycle recorder ----------------
  logic        rec_breq [64];
  logic        rec_bw   [64];
  logic        rec_iv   [64];
  logic        rec_dv   [64];
  logic        rec_si   [64];
  logic        rec_sd   [64];
  logic [31:0] rec_baddr[64];
  logic [31:0] rec_bwd  [64];
  logic [31:0] rec_idata[64];
  logic [31:0] rec_ddata[64];
  logic [3:0]  rec_strk [64];
  logic        auto_drop = 1'b1;

  // Sample cycle c mid-cycle, then advance to just after the next edge,
  // retiring any request whose response was seen (well-behaved requester).
  task automatic step_rec(input int c);
    logic drop_i, drop_d;
    @(negedge clk);
    rec_breq[c]  = mb.bus_req;
    rec_bw[c]    = mb.bus_write;
    rec_iv[c]    = mb.iresp_valid;
    rec_dv[c]    = mb.dresp_valid;
    rec_si[c]    = mb.stall_i;
    rec_sd[c]    = mb.stall_d;
    rec_baddr[c] = mb.bus_addr;
    rec_bwd[c]   = mb.bus_wdata;
    rec_idata[c] = mb.iresp_data;
    rec_ddata[c] = mb.dresp_data;
    rec_strk[c]  = dut.u_streak.streak_p0;
    drop_i = mb.iresp_valid;
    drop_d = mb.dresp_valid;
    @(posedge clk);
    #1;
    if (auto_drop && drop_i) mb.ireq_valid = 1'b0;
    if (auto_drop && drop_d) mb.dreq_valid = 1'b0;
  endtask

  int exp_ord[6] = '{2, 2, 2, 2, 1, 2};
  int g0;

  initial begin
    mb.ireq_valid = 1'b0; mb.ireq_addr = 32'h0;
    mb.dreq_valid = 1'b0; mb.dreq_write = 1'b0; mb.dreq_addr = 32'h0;
    mb.dreq_size  = MSIZE_BYTE; mb.dreq_wdata = 32'h0;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus_req",    32'(mb.bus_req),     32'd0);
    chk("rst_bus_addr",   mb.bus_addr,         32'd0);
    chk("rst_iresp_vld",  32'(mb.iresp_valid), 32'd0);
    chk("rst_dresp_data", mb.dresp_data,       32'd0);
    resetn = 1'b1;
    step_rec(0);

    // ---- lone load, ack in cycle 3 ----
    mb.dreq_valid = 1'b1; mb.dreq_write = 1'b0; mb.dreq_addr = 32'h8000_0010;
    mb.dreq_size = MSIZE_WORD; ack_lat = 3; rd_fixed_en = 1'b1; rd_fixed = 32'hDEAD_BEEF;
    for (int c = 0; c < 7; c++) step_rec(c);
    chk("load_breq_c0", 32'(rec_breq[0]), 32'd0);
    chk("load_breq_c1", 32'(rec_breq[1]), 32'd1);
    chk("load_breq_c3", 32'(rec_breq[3]), 32'd1);
    chk("load_breq_c4", 32'(rec_breq[4]), 32'd0);
    chk("load_dv_c3",   32'(rec_dv[3]),   32'd0);
    chk("load_dv_c4",   32'(rec_dv[4]),   32'd1);
    chk("load_dv_c5",   32'(rec_dv[5]),   32'd0);
    chk("load_data_c4", rec_ddata[4],     32'hDEAD_BEEF);
    chk("load_sd_c0",   32'(rec_sd[0]),   32'd1);
    chk("load_sd_c3",   32'(rec_sd[3]),   32'd1);
    chk("load_sd_c4",   32'(rec_sd[4]),   32'd0);
    rd_fixed_en = 1'b0;

    // ---- collision: store and fetch raised together ----
    ack_lat = 1;
    mb.ireq_valid = 1'b1; mb.ireq_addr = 32'h0000_0200;
    mb.dreq_valid = 1'b1; mb.dreq_write = 1'b1; mb.dreq_addr = 32'h0000_0100;
    mb.dreq_size = MSIZE_WORD; mb.dreq_wdata = 32'h1234_5678;
    for (int c = 0; c < 6; c++) step_rec(c);
    chk("col_addr_c1",  rec_baddr[1],     32'h0000_0100);
    chk("col_write_c1", 32'(rec_bw[1]),   32'd1);
    chk("col_wdata_c1", rec_bwd[1],       32'h1234_5678);
    chk("col_dv_c2",    32'(rec_dv[2]),   32'd1);
    chk("col_breq_c2",  32'(rec_breq[2]), 32'd0);
    chk("col_addr_c3",  rec_baddr[3],     32'h0000_0200);
    chk("col_write_c3", 32'(rec_bw[3]),   32'd0);
    chk("col_si_c3",    32'(rec_si[3]),   32'd1);
    chk("col_iv_c4",    32'(rec_iv[4]),   32'd1);
    chk("col_idata_c4", rec_idata[4],     32'hC0DE_0200);
    chk("col_si_c4",    32'(rec_si[4]),   32'd0);

    // ---- starvation guard: fetch reasserted at each data decision ----
    auto_drop = 1'b0;
    g0 = m_grants.size();
    mb.ireq_addr = 32'h0000_0300;
    mb.dreq_write = 1'b0; mb.dreq_addr = 32'h0000_0400; mb.dreq_size = MSIZE_HALF;
    mb.dreq_wdata = 32'h0;
    for (int c = 0; c < 18; c++) begin
      mb.ireq_valid = ((c <= 9) && (c % 3 == 0)) || ((c >= 12) && (c <= 14));
      mb.dreq_valid = (c <= 16);
      step_rec(c);
    end
    chk("stv_addr_c1",   rec_baddr[1],    32'h0000_0400);
    chk("stv_addr_c10",  rec_baddr[10],   32'h0000_0400);
    chk("stv_breq_c12",  32'(rec_breq[12]), 32'd0);
    chk("stv_addr_c13",  rec_baddr[13],   32'h0000_0300);
    chk("stv_iv_c14",    32'(rec_iv[14]), 32'd1);
    chk("stv_addr_c15",  rec_baddr[15],   32'h0000_0400);
    chk("stv_size_c15",  32'(rec_bw[15]), 32'd0);
    chk("stv_streak_c10", 32'(rec_strk[10]), 32'd4);
    chk("stv_streak_c13", 32'(rec_strk[13]), 32'd0);
    chk("stv_ngrants", 32'(m_grants.size() - g0), 32'd6);
    for (int k = 0; k < 6; k++)
      if (g0 + k < m_grants.size()) chk("stv_order", 32'(m_grants[g0 + k]), 32'(exp_ord[k]));

    // ---- response-cycle masking: dreq held past its response ----
    mb.ireq_valid = 1'b0;
    mb.dreq_addr = 32'h0000_0500; mb.dreq_size = MSIZE_WORD;
    for (int c = 0; c < 8; c++) begin
      mb.dreq_valid = (c <= 5);
      step_rec(c);
    end
    chk("msk_dv_c2",   32'(rec_dv[2]),   32'd1);
    chk("msk_breq_c2", 32'(rec_breq[2]), 32'd0);
    chk("msk_breq_c3", 32'(rec_breq[3]), 32'd0);
    chk("msk_breq_c4", 32'(rec_breq[4]), 32'd1);
    chk("msk_dv_c5",   32'(rec_dv[5]),   32'd1);

    // ---- spurious ack while idle ----
    auto_drop = 1'b1;
    slave_en = 1'b0; man_ack = 1'b1; rd_fixed_en = 1'b1; rd_fixed = 32'hBAD0_BAD0;
    step_rec(0);
    step_rec(1);
    man_ack = 1'b0;
    step_rec(2);
    chk("spu_breq_c1",  32'(rec_breq[1]), 32'd0);
    chk("spu_dv_c1",    32'(rec_dv[1]),   32'd0);
    chk("spu_iv_c2",    32'(rec_iv[2]),   32'd0);
    chk("spu_ddata_c2", rec_ddata[2],     32'hC0DE_0500);
    chk("spu_idata_c2", rec_idata[2],     32'hC0DE_0300);
    slave_en = 1'b1; rd_fixed_en = 1'b0;
    mb.dreq_valid = 1'b1; mb.dreq_addr = 32'h0000_0800;
    for (int c = 0; c < 5; c++) step_rec(c);
    chk("spu_next_breq", 32'(rec_breq[1]), 32'd1);
    chk("spu_next_addr", rec_baddr[1],     32'h0000_0800);
    chk("spu_next_data", rec_ddata[2],     32'hC0DE_0800);

    // ---- reset during a data transaction ----
    auto_drop = 1'b0;
    ack_lat = 5;
    mb.dreq_valid = 1'b1; mb.dreq_addr = 32'h0000_0600;
    step_rec(0);
    step_rec(1);
    chk("rmt_breq_c1", 32'(rec_breq[1]), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("rmt_breq_async", 32'(mb.bus_req),     32'd0);
    chk("rmt_addr_async", mb.bus_addr,         32'd0);
    chk("rmt_dv_async",   32'(mb.dresp_valid), 32'd0);
    mb.dreq_valid = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    auto_drop = 1'b1;
    ack_lat = 2;
    mb.ireq_valid = 1'b1; mb.ireq_addr = 32'h0000_0700;
    for (int c = 0; c < 6; c++) step_rec(c);
    chk("rmt_dv_c0",    32'(rec_dv[0]),   32'd0);
    chk("rmt_breq_c1f", 32'(rec_breq[1]), 32'd1);
    chk("rmt_breq_c2f", 32'(rec_breq[2]), 32'd1);
    chk("rmt_iv_c3",    32'(rec_iv[3]),   32'd1);
    chk("rmt_idata_c3", rec_idata[3],     32'hC0DE_0700);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the instruction-fetch read port and the memory-stage data port onto the single shared memory bus, one transaction at a time. It latches the granted request, holds it stable on the bus until the slave acknowledges, and returns read data as a registered one-cycle response. It also drives per-requester stall lines to the hazard unit. Data requests win over fetch, bounded by a streak counter so fetch cannot starve.

## Interface
- MAX_D_STREAK, 4: consecutive data grants allowed while a fetch request is pending before fetch is forced; legal range 1–15.
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ireq_valid  in  1  fetch read request; held with ireq_addr until iresp_valid.
- ireq_addr  in  32  fetch address; size is always word.
- iresp_valid  out  1  one-cycle pulse: fetch read complete.
- iresp_data  out  32  fetch read data; valid with iresp_valid, otherwise holds last value.
- dreq_valid  in  1  memory-stage request; held with all dreq fields until dresp_valid.
- dreq_write  in  1  1 = store, 0 = load.
- dreq_addr  in  32  data address.
- dreq_size  in  2  msize_t: 0 = byte, 1 = half, 2 = word.
- dreq_wdata  in  32  store data, already lane-aligned by the memory stage.
- dresp_valid  out  1  one-cycle pulse: data transaction complete (loads and stores).
- dresp_data  out  32  load data; valid with dresp_valid.
- stall_i  out  1  fetch must hold.
- stall_d  out  1  memory stage must hold.
- bus_req  out  1  bus transaction active.
- bus_write, bus_addr[32], bus_size[2], bus_wdata[32]  out  bus command; stable while bus_req = 1.
- bus_ack  in  1  slave completion; sampled only while bus_req = 1.
- bus_rdata  in  32  read data; valid when bus_ack = 1.

## Operation
- **FSM states:** IDLE, IBUS, DBUS; reset state IDLE.
- **IDLE, grant rules:**
  - Effective requests are ireq_valid && !iresp_valid and dreq_valid && !dresp_valid. A requester is never granted in its own response cycle.
  - Data effective only: grant D.
  - Fetch effective only: grant I.
  - Both effective: grant I if streak == MAX_D_STREAK, otherwise grant D.
  - On grant, the command (addr, size, write, wdata) is latched into the bus registers and the FSM moves to IBUS or DBUS. A fetch command is always write = 0, size = word, wdata = 0.
- **IBUS/DBUS:**
  - bus_req = 1 and the command registers are frozen.
  - On bus_ack, the edge captures bus_rdata into the matching resp_data, pulses the matching resp_valid next cycle, and returns to IDLE.
- **Streak counter (4 bits):**
  - D grant with fetch effective: increment, saturating at MAX_D_STREAK.
  - Any I grant: clear.
  - D grant with no fetch pending: clear.
- **Stalls (combinational):**
  - stall_i = ireq_valid && !iresp_valid.
  - stall_d = dreq_valid && !dresp_valid.
- **Requests held after a response** (cycle after the resp pulse or later) are treated as new requests.
- **Reset, including mid-transaction:**
  - All outputs go to 0 immediately and the FSM returns to IDLE; any outstanding bus transaction is abandoned.
  - bus_req, iresp_valid, dresp_valid, bus_write, bus_size, bus_addr, bus_wdata, iresp_data and dresp_data all reset to 0; streak resets to 0.
- **Stores:** dresp_data is undefined-but-stable; its content is not checked.

## Timing
- Request first effective in cycle 0 with FSM IDLE: bus_req = 1 from cycle 1.
- bus_ack in cycle k (k ≥ 1): resp_valid = 1 in cycle k+1 only; bus_req = 0 in cycle k+1.
- Next grant decision in cycle k+1; next bus_req no earlier than cycle k+2.
- Minimum latency, request to response: 2 cycles. Zero-wait slave throughput: one transaction per 2 cycles.
- bus_ack while bus_req = 0 is ignored.
- Requests changing while latched do not affect the bus. A held-request violation is a requester bug and is not detected.

## Structure
- Add to memory_pkg:
  - msize_t.
  - arb_state_t enum {IDLE, IBUS, DBUS}.
  - bus_cmd_t struct {write, size, addr, wdata}.
- Optional sub-module arb_streak_ctr: the saturating counter plus the force-fetch compare. All other logic stays in one module.

## Test plan
- **Lone load:** dreq_valid, addr 0x8000_0010, size 2, bus_ack in cycle 3 with rdata 0xDEAD_BEEF → bus_req cycles 1–3, dresp_valid cycle 4 only, dresp_data 0xDEAD_BEEF, stall_d high cycles 0–3.
- **Collision:** ireq and dreq (store 0x1234_5678 @ 0x100, size 2) both raised in cycle 0, slave acks in 1 cycle → D on bus first, then I. stall_i stays high until iresp_valid.
- **Starvation guard:** MAX_D_STREAK = 4, ireq held, five back-to-back dreqs → grant order D, D, D, D, I, D; streak reads 0 after the I grant.
- **Response-cycle masking:** dreq held one extra cycle after dresp_valid → no regrant in the response cycle, new bus_req two cycles later.
- **Reset mid-transaction:** resetn low during DBUS → bus_req = 0 asynchronously, no dresp_valid. After release, a fresh ireq completes normally.
- **Spurious ack:** bus_ack pulsed in IDLE → no resp pulse, no state change.
